bus_request_sequencer: RTL and testbench
========================================

# bus_request_sequencer

Upstream stage of the simple-bus processor-side master. It accepts read/write commands from a client through a valid/ready handshake and buffers them in a small FIFO. It issues the commands one at a time to the bus master through that master's access/doRead/address/data request port, and returns one response per command, with read data or a timeout error. It sits between the client (CPU model or traffic generator) and the processor-side bus thread, and guarantees that the master never sees overlapping accesses.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- ADDR_W, 16, command address width
- DATA_W, 8, data width
- TIMEOUT, 12, max cycles in WAIT before error response (bus read ≤10, write ≤7)

Ports:
- clock  in  1  single clock, all state on posedge
- resetN  in  1  asynchronous, active-low reset
- cmd_valid  in  1  client command present
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_read  in  1  1 = read, 0 = write
- cmd_addr  in  ADDR_W  command address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_error  out  1  timeout flag, qualified by rsp_valid
- m_access  out  1  one-cycle transaction start to master
- m_read  out  1  maps to master doRead
- m_addr  out  ADDR_W  maps to master AddrReg
- m_wdata  out  DATA_W  maps to master DataReg
- m_wdata_rdy  out  1  maps to master wDataRdy
- m_done  in  1  master completion pulse (read data loaded / write dataValid driven)
- m_rdata  in  DATA_W  master read data, valid with m_done

## Operation
- FIFO: push on cmd_valid && cmd_ready. Pop only in RESP. No bypass: when full, cmd_ready = 0 even if a pop occurs in that cycle. Occupancy counter is $clog2(DEPTH+1) bits wide. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO non-empty, go to ISSUE; else stay.
  - ISSUE: m_access = 1 for exactly one cycle; go to WAIT; clear the timeout counter.
  - WAIT: on m_done, capture m_rdata (reads only), clear the error flag, go to RESP. Otherwise increment the counter; when counter == TIMEOUT−1 without m_done, set the error flag and go to RESP.
  - RESP: rsp_valid = 1 for one cycle; pop the FIFO head; go to IDLE.
- m_read, m_addr and m_wdata present the FIFO head and are held stable from ISSUE through RESP.
- m_wdata_rdy = 1 in ISSUE and WAIT for writes only.
- m_done is ignored outside WAIT.
- rsp_rdata = captured data for successful reads, otherwise 0.

## Timing
- Reset values: cmd_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, m_access = 0, m_read = 0, m_addr = 0, m_wdata = 0, m_wdata_rdy = 0. State = IDLE, FIFO empty.
- Command accepted at edge N into an empty FIFO in IDLE: ISSUE during cycle N+1 to N+2, so m_access is high one cycle after acceptance.
- m_done sampled high in WAIT at edge K: rsp_valid high in cycle K to K+1.
- Back-to-back commands: minimum 4 cycles between consecutive m_access pulses (ISSUE, WAIT ≥1, RESP, IDLE).
- Timeout: the error response is produced after exactly TIMEOUT cycles in WAIT.
- Reset mid-transaction: asynchronous return to reset values. The FIFO is flushed, in-flight and queued commands are lost, and no response is generated.

## Structure
- Package bus_seq_pkg holds:
  - typedef enum for {IDLE, ISSUE, WAIT, RESP}
  - typedef struct packed bus_cmd_t {read, addr, wdata}
  - TIMEOUT default constant
- Sub-module bus_cmd_fifo (parameterised DEPTH, payload bus_cmd_t). It provides push/pop, head output, full, empty and count, with asynchronous active-low reset on clock and resetN.
- The top module contains the FSM, timeout counter and response registers.

## Test plan
- Write 0x0406 = 0xDC, master m_done 3 cycles after m_access → m_access one cycle after accept, m_wdata_rdy = 1, m_addr = 0x0406 held; rsp_valid with rsp_error = 0, rsp_rdata = 0.
- Read 0x0406, m_done with m_rdata = 0xDC after 5 cycles → rsp_valid, rsp_rdata = 0xDC, rsp_error = 0; m_wdata_rdy stays 0.
- Push 5 commands back-to-back with DEPTH = 4, master never completing within the window → cmd_ready drops after the 4th accept. The 5th is accepted only after the first RESP pop. Responses come out in order.
- No m_done for a read → rsp_valid with rsp_error = 1 and rsp_rdata = 0 exactly TIMEOUT cycles after entering WAIT; the FSM then serves the next command.
- Assert resetN low during WAIT with 3 queued commands → all outputs at reset values immediately; no rsp_valid after release; cmd_ready = 1.
- m_done pulsed during ISSUE and during IDLE → ignored; no spurious rsp_valid.

Source files
------------

// File: rtl/bus_request_sequencer_pkg.sv
// Shared types for the bus request sequencer: FSM states, queued command
// record and default sizing constants.
package bus_seq_pkg;

  localparam int CMD_ADDR_W  = 16;
  localparam int CMD_DATA_W  = 8;
  localparam int TIMEOUT_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

  // Fields are sized for the widest supported bus; narrower buses zero-extend.
  typedef struct packed {
    logic                  read;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } bus_cmd_t;

endpackage

// File: rtl/bus_request_sequencer_fifo.sv
// Command FIFO for the bus request sequencer: DEPTH entries of bus_cmd_t,
// no bypass, head visible combinationally.
module bus_cmd_fifo
  import bus_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic                         push,
  input  bus_cmd_t                     push_data,
  input  logic                         pop,
  output bus_cmd_t                     head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  bus_cmd_t          mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bus_request_sequencer.sv
// Serialises queued client read/write commands onto the simple-bus master
// request port, one at a time, with a per-access timeout.
module bus_request_sequencer
  import bus_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = CMD_ADDR_W,
  parameter int DATA_W  = CMD_DATA_W,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_read,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              m_access,
  output logic              m_read,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wdata_rdy,
  input  logic              m_done,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int TMO_W = $clog2(TIMEOUT+1);

  seq_state_t        state;
  bus_cmd_t          cmd_in;
  bus_cmd_t          head;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  assign cmd_in = '{read:  cmd_read,
                    addr:  CMD_ADDR_W'(cmd_addr),
                    wdata: CMD_DATA_W'(cmd_wdata)};

  bus_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .resetN    (resetN),
    .push      (cmd_valid && cmd_ready),
    .push_data (cmd_in),
    .pop       ((state == RESP) && !empty),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign cmd_ready   = !full;
  assign m_access    = (state == ISSUE);
  assign m_wdata_rdy = ((state == ISSUE) || (state == WAIT)) && !m_read;
  assign rsp_valid   = (state == RESP);
  assign rsp_error   = rsp_valid && err_q;
  assign rsp_rdata   = rsp_valid ? rdata_q : '0;

  // The head is latched on leaving IDLE so the master sees a stable request
  // until the response pops it.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
      m_read  <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state   <= ISSUE;
            m_read  <= head.read;
            m_addr  <= ADDR_W'(head.addr);
            m_wdata <= DATA_W'(head.wdata);
          end
        end
        ISSUE: begin
          state   <= WAIT;
          tmo_cnt <= '0;
        end
        WAIT: begin
          if (m_done) begin
            err_q <= 1'b0;
            state <= RESP;
          end else if (tmo_cnt == TMO_W'(TIMEOUT-1)) begin
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Only ever observed through rsp_rdata while in RESP, after a WAIT load.
  always_ff @(posedge clock) begin
    if (state == WAIT) begin
      if (m_done)
        rdata_q <= m_read ? m_rdata : '0;
      else if (tmo_cnt == TMO_W'(TIMEOUT-1))
        rdata_q <= '0;
    end
  end

endmodule

// File: tb/tb_bus_request_sequencer.sv
// Randomised bench for bus_request_sequencer with a transaction-level
// reference model of queue occupancy, access timing and responses.
module tb_bus_request_sequencer;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 12;

  logic              clock = 1'b0;
  logic              resetN;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_read;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;
  logic              m_access;
  logic              m_read;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_wdata_rdy;
  logic              m_done;
  logic [DATA_W-1:0] m_rdata;

  bus_request_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock       (clock),
    .resetN      (resetN),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_read    (cmd_read),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .m_access    (m_access),
    .m_read      (m_read),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_wdata_rdy (m_wdata_rdy),
    .m_done      (m_done),
    .m_rdata     (m_rdata)
  );

  always #5 clock = ~clock;

  // A command plus the bench master's behaviour for it: m_done is driven in
  // the d-th cycle after the m_access cycle; d > TIMEOUT means "too late".
  typedef struct {
    logic              read;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                d;
    logic [DATA_W-1:0] rdata;
  } ent_t;

  ent_t q[$];
  ent_t dir[$];
  ent_t pend;
  bit   pend_v;
  bit   busy;
  int   age;
  bit   prev_idle_ne;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_reset_values();
    check("rst_cmd_ready",   32'(cmd_ready),   32'd1);
    check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    check("rst_rsp_rdata",   32'(rsp_rdata),   32'd0);
    check("rst_rsp_error",   32'(rsp_error),   32'd0);
    check("rst_m_access",    32'(m_access),    32'd0);
    check("rst_m_read",      32'(m_read),      32'd0);
    check("rst_m_addr",      32'(m_addr),      32'd0);
    check("rst_m_wdata",     32'(m_wdata),     32'd0);
    check("rst_m_wdata_rdy", 32'(m_wdata_rdy), 32'd0);
  endtask

  function automatic ent_t mk(input logic rd, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] wd, input int d,
                              input logic [DATA_W-1:0] rdat);
    ent_t e;
    e.read = rd; e.addr = a; e.wdata = wd; e.d = d; e.rdata = rdat;
    return e;
  endfunction

  function automatic void model_clear();
    q.delete();
    pend_v       = 1'b0;
    busy         = 1'b0;
    age          = 0;
    prev_idle_ne = 1'b0;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input int vld_pct, input int d_lo, input int d_hi);
    bit   exp_acc, exp_rsp, exp_err, accept, new_prev;
    int   rsp_age;
    ent_t cur;
    exp_acc = !busy && prev_idle_ne;
    if (exp_acc) begin
      busy = 1'b1;
      age  = 0;
    end
    cur     = busy ? q[0] : mk(1'b0, '0, '0, 0, '0);
    rsp_age = ((cur.d > TIMEOUT) ? TIMEOUT : cur.d) + 1;
    exp_rsp = busy && (age == rsp_age);
    exp_err = cur.d > TIMEOUT;

    check("m_access",  32'(m_access),  32'(exp_acc));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rsp) begin
      check("rsp_error", 32'(rsp_error), 32'(exp_err));
      check("rsp_rdata", 32'(rsp_rdata), (cur.read && !exp_err) ? 32'(cur.rdata) : 32'd0);
    end
    if (busy) begin
      check("m_read",      32'(m_read),      32'(cur.read));
      check("m_addr",      32'(m_addr),      32'(cur.addr));
      check("m_wdata",     32'(m_wdata),     32'(cur.wdata));
      check("m_wdata_rdy", 32'(m_wdata_rdy), 32'(!cur.read && age < rsp_age));
    end else begin
      check("m_wdata_rdy_idle", 32'(m_wdata_rdy), 32'd0);
    end
    check("cmd_ready", 32'(cmd_ready), 32'(q.size() < DEPTH));

    // Master side: the real completion, or a stray pulse where it must be ignored.
    m_rdata = DATA_W'($urandom);
    if (busy && age == cur.d) begin
      m_done  = 1'b1;
      m_rdata = cur.rdata;
    end else if ((!busy || age == 0 || age >= rsp_age) && $urandom_range(0, 4) == 0)
      m_done = 1'b1;
    else
      m_done = 1'b0;

    // Client side: hold a presented command until it is accepted.
    if (!pend_v) begin
      if (dir.size() > 0) begin
        pend   = dir.pop_front();
        pend_v = 1'b1;
      end else if ($urandom_range(0, 99) < vld_pct) begin
        pend   = mk(1'(($urandom)), ADDR_W'($urandom), DATA_W'($urandom),
                    $urandom_range(d_lo, d_hi), DATA_W'($urandom));
        pend_v = 1'b1;
      end
    end
    cmd_valid = pend_v;
    cmd_read  = pend.read;
    cmd_addr  = pend.addr;
    cmd_wdata = pend.wdata;
    accept    = pend_v && (q.size() < DEPTH);

    new_prev = !busy && (q.size() > 0);
    if (exp_rsp) begin
      void'(q.pop_front());
      busy = 1'b0;
    end else if (busy) begin
      age++;
    end
    if (accept) begin
      q.push_back(pend);
      pend_v = 1'b0;
    end
    prev_idle_ne = new_prev;
    @(negedge clock);
  endtask

  initial begin
    int budget;
    resetN    = 1'b0;
    cmd_valid = 1'b0;
    cmd_read  = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    m_done    = 1'b0;
    m_rdata   = '0;
    pend      = mk(1'b0, '0, '0, 1, '0);
    model_clear();
    repeat (2) @(negedge clock);
    check_reset_values();
    resetN = 1'b1;

    // Write 0x0406=0xDC (done after 3), then read it back (done after 5).
    dir.push_back(mk(1'b0, 16'h0406, 8'hDC, 3, 8'h00));
    dir.push_back(mk(1'b1, 16'h0406, 8'h00, 5, 8'hDC));
    repeat (30) step(0, 1, 1);

    // Read that never completes, then a write that must still be served.
    dir.push_back(mk(1'b1, 16'h1234, 8'h00, TIMEOUT + 1, 8'h5A));
    dir.push_back(mk(1'b0, 16'h0BEE, 8'h77, 2, 8'h00));
    repeat (30) step(0, 1, 1);

    // Five back-to-back commands into a four-deep FIFO, all timing out.
    for (int i = 0; i < 5; i++)
      dir.push_back(mk(1'(i), 16'(16'h2000 + i), 8'(8'h10 + i), TIMEOUT + 1, 8'(8'hA0 + i)));
    repeat (5 * (TIMEOUT + 4) + 5) step(0, 1, 1);

    // Mixed random traffic including exact-boundary completions.
    repeat (1500) step(30, 1, TIMEOUT + 1);

    // Build a full queue with an access in WAIT, then reset asynchronously.
    budget = 0;
    while (!(busy && age == 2 && q.size() == DEPTH) && budget < 60) begin
      step(100, TIMEOUT, TIMEOUT + 1);
      budget++;
    end
    check("rst_setup_reached", 32'(budget < 60), 32'd1);
    #2 resetN = 1'b0;
    cmd_valid = 1'b0;
    m_done    = 1'b0;
    #1 check_reset_values();
    @(negedge clock);
    @(negedge clock);
    resetN = 1'b1;
    model_clear();
    repeat (5) step(0, 1, 1);

    repeat (300) step(40, 1, TIMEOUT + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
